// File: rtl/uart_rx_stdin.sv
// 8N1 serial receiver for the SoC stdin path: 2-FF synchroniser, mid-bit
// sampling FSM and a first-word-fall-through byte FIFO with valid/ready.
module uart_rx_stdin #(
  parameter int unsigned CLOCK_FREQUENCY = 50000000,
  parameter int unsigned BAUD_RATE       = 115200,
  parameter int unsigned FIFO_DEPTH      = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       framing_error,
  output logic       overrun
);

  localparam int unsigned BIT_TIME = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int unsigned HALF     = BIT_TIME / 2;
  localparam int unsigned TMR_W    = $clog2(BIT_TIME);
  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t             state, state_nxt;
  logic [TMR_W-1:0]   timer, timer_nxt;
  logic [2:0]         bit_idx, bit_idx_nxt;
  logic [7:0]         shreg, shreg_nxt;
  logic               rx_meta, rx_sync;
  logic               push_c, ferr_c;

  logic [7:0]         mem [FIFO_DEPTH];
  logic [CNT_W-1:0]   wr_ptr, rd_ptr;
  logic               full_c, pop_c, wr_en_c, ovr_c;

  // Two-flop synchroniser; idles high so reset never looks like a start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      bit_idx <= bit_idx_nxt;
      shreg   <= shreg_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer + TMR_W'(1);
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    push_c      = 1'b0;
    ferr_c      = 1'b0;
    case (state)
      S_IDLE: begin
        timer_nxt = '0;
        if (!rx_sync) state_nxt = S_START;
      end
      S_START: begin
        // Re-check at the middle of the start bit to reject line glitches
        if (timer == TMR_W'(HALF - 1)) begin
          timer_nxt = '0;
          if (!rx_sync) begin
            state_nxt   = S_DATA;
            bit_idx_nxt = '0;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (timer == TMR_W'(BIT_TIME - 1)) begin
          timer_nxt          = '0;
          shreg_nxt[bit_idx] = rx_sync;
          if (bit_idx == 3'd7) state_nxt = S_STOP;
          else bit_idx_nxt = bit_idx + 3'd1;
        end
      end
      S_STOP: begin
        if (timer == TMR_W'(BIT_TIME - 1)) begin
          timer_nxt = '0;
          if (rx_sync) begin
            push_c    = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            ferr_c    = 1'b1;
            state_nxt = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        timer_nxt = '0;
        if (rx_sync) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        timer_nxt = '0;
      end
    endcase
  end

  // FIFO: a push into a full FIFO is accepted when the head leaves on the same edge
  assign out_valid = (wr_ptr != rd_ptr);
  assign full_c    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop_c     = out_valid & out_ready;
  assign wr_en_c   = push_c & (~full_c | pop_c);
  assign ovr_c     = push_c & full_c & ~pop_c;
  assign out_data  = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (wr_en_c) begin
      mem[wr_ptr[PTR_W-1:0]] <= shreg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      if (wr_en_c) wr_ptr <= wr_ptr + CNT_W'(1);
      if (pop_c)   rd_ptr <= rd_ptr + CNT_W'(1);
      framing_error <= ferr_c;
      overrun       <= ovr_c;
    end
  end

endmodule
